vga_param_controller: RTL and testbench

VGA_PARAM_CONTROLLER -- requirements
Module: vga_param_controller

---
 rtl/vga_param_controller.sv | 197 +++++++++++++++++++
 tb/tb_vga_param_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_param_controller.sv
// VGA timing generator with frame-buffer fetch; VGA_CURSOR_EN adds a crosshair cursor overlay.
// Fetch is registered 1 clk after the counters; pixel out RD_LAT+1 clks after fetch; free-running, no backpressure.
module vga_param_controller #(
  parameter int   H_ACT      = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACT      = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   COLOR_W    = 10,
  parameter int   ADDR_W     = 20,
  parameter int   RD_LAT     = 2,
  parameter int   SCALE_LOG2 = 0
) (
  input  logic               iCLK,
  input  logic               iRST,
`ifdef VGA_CURSOR_EN
  input  logic               iCursor_EN,
  input  logic [10:0]        iCursor_X,
  input  logic [10:0]        iCursor_Y,
  input  logic [COLOR_W-1:0] iCursor_R,
  input  logic [COLOR_W-1:0] iCursor_G,
  input  logic [COLOR_W-1:0] iCursor_B,
`endif
  output logic               oRead,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [10:0]        oCoord_X,
  output logic [10:0]        oCoord_Y,
  output logic               oFrame_Start,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int H_SS    = H_ACT + H_FP;
  localparam int H_SE    = H_SS + H_SYNC;
  localparam int V_SS    = V_ACT + V_FP;
  localparam int V_SE    = V_SS + V_SYNC;
  localparam int D       = RD_LAT + 1;
  localparam logic [10:0]       SC_MASK   = 11'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACT >> SCALE_LOG2);

  logic [10:0]        r_h, r_v;
  logic               w_h_last, w_v_last, w_h_act, w_v_act, w_fetch;
  logic               r_read, r_fs, r_hs_f, r_vs_f;
  logic [10:0]        r_x, r_y;
  logic [ADDR_W-1:0]  r_addr, r_line_base;
  logic [D-1:0]       r_d_blank, r_d_hs, r_d_vs;
  logic [COLOR_W-1:0] r_r, r_g, r_b;
  logic               w_pix_vld;

  assign w_h_last = (r_h == 11'(H_TOTAL - 1));
  assign w_v_last = (r_v == 11'(V_TOTAL - 1));
  assign w_h_act  = (r_h < 11'(H_ACT));
  assign w_v_act  = (r_v < 11'(V_ACT));
  assign w_fetch  = w_h_act && w_v_act;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? 11'd0 : r_v + 11'd1;
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  // Address walks forward every 2^SCALE_LOG2 pixels; each line restarts from the line base,
  // which steps by one scaled line every 2^SCALE_LOG2 active lines and clears at frame end.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_read      <= 1'b0;
      r_fs        <= 1'b0;
      r_hs_f      <= 1'b0;
      r_vs_f      <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_line_base <= '0;
    end else begin
      r_read <= w_fetch;
      r_fs   <= (r_h == 11'd0) && (r_v == 11'd0);
      r_hs_f <= (r_h >= 11'(H_SS)) && (r_h < 11'(H_SE));
      r_vs_f <= (r_v >= 11'(V_SS)) && (r_v < 11'(V_SE));
      r_x    <= r_h;
      r_y    <= r_v;
      if (w_fetch) begin
        if (r_h == 11'd0)
          r_addr <= r_line_base;
        else if ((r_h & SC_MASK) == 11'd0)
          r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_h_last) begin
        if (w_v_last)
          r_line_base <= '0;
        else if (w_v_act && (((r_v + 11'd1) & SC_MASK) == 11'd0))
          r_line_base <= r_line_base + LINE_STEP;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_d_blank <= '0;
      r_d_hs    <= '0;
      r_d_vs    <= '0;
    end else begin
      r_d_blank <= {r_d_blank[D-2:0], r_read};
      r_d_hs    <= {r_d_hs[D-2:0], r_hs_f};
      r_d_vs    <= {r_d_vs[D-2:0], r_vs_f};
    end
  end

  // Stage RD_LAT-1 lines up with the read data arriving this clock.
  assign w_pix_vld = r_d_blank[RD_LAT-1];

`ifdef VGA_CURSOR_EN
  logic [10:0] r_d_x [RD_LAT];
  logic [10:0] r_d_y [RD_LAT];
  logic [11:0] w_px, w_py, w_cx, w_cy;
  logic        w_x_near, w_y_near, w_cur_on, w_cur_hit;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_d_x[i] <= '0;
        r_d_y[i] <= '0;
      end
    end else begin
      r_d_x[0] <= r_x;
      r_d_y[0] <= r_y;
      for (int i = 1; i < RD_LAT; i++) begin
        r_d_x[i] <= r_d_x[i-1];
        r_d_y[i] <= r_d_y[i-1];
      end
    end
  end

  // One extra bit keeps the +/-1 window from wrapping at either screen edge.
  assign w_px      = {1'b0, r_d_x[RD_LAT-1]};
  assign w_py      = {1'b0, r_d_y[RD_LAT-1]};
  assign w_cx      = {1'b0, iCursor_X};
  assign w_cy      = {1'b0, iCursor_Y};
  assign w_x_near  = (w_px + 12'd1 >= w_cx) && (w_px <= w_cx + 12'd1);
  assign w_y_near  = (w_py + 12'd1 >= w_cy) && (w_py <= w_cy + 12'd1);
  assign w_cur_on  = (iCursor_X < 11'(H_ACT)) && (iCursor_Y < 11'(V_ACT));
  assign w_cur_hit = iCursor_EN && w_cur_on && (w_x_near || w_y_near);
`endif

  always_ff @(posedge iCLK) begin
    if (iRST || !w_pix_vld) begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
`ifdef VGA_CURSOR_EN
    end else if (w_cur_hit) begin
      r_r <= iCursor_R;
      r_g <= iCursor_G;
      r_b <= iCursor_B;
`endif
    end else begin
      r_r <= iRed;
      r_g <= iGreen;
      r_b <= iBlue;
    end
  end

  assign oRead        = r_read;
  assign oAddress     = r_addr;
  assign oCoord_X     = r_x;
  assign oCoord_Y     = r_y;
  assign oFrame_Start = r_fs;
  assign oVGA_R       = r_r;
  assign oVGA_G       = r_g;
  assign oVGA_B       = r_b;
  assign oVGA_BLANK   = r_d_blank[D-1];
  assign oVGA_H_SYNC  = r_d_hs[D-1] ? SYNC_POL : ~SYNC_POL;
  assign oVGA_V_SYNC  = r_d_vs[D-1] ? SYNC_POL : ~SYNC_POL;
  assign oVGA_SYNC    = 1'b0;
  assign oVGA_CLOCK   = iCLK;

endmodule

// File: tb/tb_vga_param_controller.sv
// Bench for vga_param_controller on a 15x8 raster; second instance runs with 2x scaling.
// Cursor checks are compiled in only when VGA_CURSOR_EN is defined.
module tb_vga_param_controller;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HT = 15;
  localparam int VT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  red = '0, green = '0, blue = '0;
  logic        o_read, o_fs, o_hs, o_vs, o_blank, o_sync, o_clk;
  logic [19:0] o_addr;
  logic [10:0] o_x, o_y;
  logic [9:0]  o_r, o_g, o_b;
  logic        s_read, s_fs, s_hs, s_vs, s_blank, s_sync, s_clk;
  logic [19:0] s_addr;
  logic [10:0] s_x, s_y;
  logic [9:0]  s_r, s_g, s_b;
`ifdef VGA_CURSOR_EN
  logic        cur_en = 1'b0;
  logic [10:0] cur_x = '0, cur_y = '0;
  logic [9:0]  cur_r = 10'h3FF, cur_g = '0, cur_b = '0;
`endif

  vga_param_controller #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .COLOR_W(10), .ADDR_W(20), .RD_LAT(2), .SCALE_LOG2(0)
  ) u_dut (
    .iCLK(clk), .iRST(rst),
`ifdef VGA_CURSOR_EN
    .iCursor_EN(cur_en), .iCursor_X(cur_x), .iCursor_Y(cur_y),
    .iCursor_R(cur_r), .iCursor_G(cur_g), .iCursor_B(cur_b),
`endif
    .oRead(o_read), .oAddress(o_addr), .iRed(red), .iGreen(green), .iBlue(blue),
    .oCoord_X(o_x), .oCoord_Y(o_y), .oFrame_Start(o_fs),
    .oVGA_R(o_r), .oVGA_G(o_g), .oVGA_B(o_b), .oVGA_H_SYNC(o_hs), .oVGA_V_SYNC(o_vs),
    .oVGA_BLANK(o_blank), .oVGA_SYNC(o_sync), .oVGA_CLOCK(o_clk)
  );

  vga_param_controller #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .COLOR_W(10), .ADDR_W(20), .RD_LAT(2), .SCALE_LOG2(1)
  ) u_dut_s (
    .iCLK(clk), .iRST(rst),
`ifdef VGA_CURSOR_EN
    .iCursor_EN(1'b0), .iCursor_X(11'd0), .iCursor_Y(11'd0),
    .iCursor_R(10'd0), .iCursor_G(10'd0), .iCursor_B(10'd0),
`endif
    .oRead(s_read), .oAddress(s_addr), .iRed(10'd0), .iGreen(10'd0), .iBlue(10'd0),
    .oCoord_X(s_x), .oCoord_Y(s_y), .oFrame_Start(s_fs),
    .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b), .oVGA_H_SYNC(s_hs), .oVGA_V_SYNC(s_vs),
    .oVGA_BLANK(s_blank), .oVGA_SYNC(s_sync), .oVGA_CLOCK(s_clk)
  );

  typedef struct packed {
    logic        rd;
    logic [10:0] x;
    logic [10:0] y;
    logic [19:0] addr;
    logic        fs;
  } fetch_t;

  typedef struct packed {
    logic        blank;
    logic        hs;
    logic        vs;
    logic [10:0] x;
    logic [10:0] y;
    logic [9:0]  r;
    logic [9:0]  g;
    logic [9:0]  b;
  } out_t;

  typedef struct {
    int x;
    int y;
    int addr;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  int          mh = 0, mv = 0;
  logic [19:0] m_addr = '0;
  fetch_t      want_f;
  out_t        want_o;
  out_t        oq[$];
  logic [19:0] hist [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  task automatic fail_bound(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s at %0t: event not seen within its cycle budget", name, $time);
  endtask

  // Predicts what the coming clock edge produces, given the inputs now applied.
  task automatic predict();
    out_t rec;
    logic rd;
    if (rst) begin
      want_f = '0;
      want_o = '0;
      oq.delete();
      repeat (3) oq.push_back('0);
      mh = 0;
      mv = 0;
      m_addr = '0;
    end else begin
      rd = (mh < HA) && (mv < VA);
      if (rd) m_addr = 20'(mv * HA + mh);
      want_f.rd   = rd;
      want_f.x    = 11'(mh);
      want_f.y    = 11'(mv);
      want_f.addr = m_addr;
      want_f.fs   = (mh == 0) && (mv == 0);
      want_o = oq.pop_front();
      rec.blank = rd;
      rec.hs    = (mh >= 10) && (mh <= 12);
      rec.vs    = (mv >= 5) && (mv <= 6);
      rec.x     = 11'(mh);
      rec.y     = 11'(mv);
      rec.r     = rd ? m_addr[9:0] : 10'd0;
      rec.g     = rd ? m_addr[9:0] + 10'd5 : 10'd0;
      rec.b     = rd ? 10'h2A5 : 10'd0;
      oq.push_back(rec);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
`ifdef VGA_CURSOR_EN
    if (cur_en && want_o.blank && (want_o.x < 11'd2 || want_o.y < 11'd2)) begin
      want_o.r = cur_r;
      want_o.g = cur_g;
      want_o.b = cur_b;
    end
`endif
  endtask

  task automatic step();
    predict();
    @(negedge clk);
    check("fetch", 64'({o_read, o_x, o_y, o_addr, o_fs}), 64'(want_f));
    check("pixel", 64'({o_blank, o_hs, o_vs, o_sync, o_r, o_g, o_b}),
          64'({want_o.blank, ~want_o.hs, ~want_o.vs, 1'b0, want_o.r, want_o.g, want_o.b}));
    // Frame buffer model: data for a fetch is presented RD_LAT clocks after it.
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = o_addr;
    red   = hist[2][9:0];
    green = hist[2][9:0] + 10'd5;
    blue  = 10'h2A5;
  endtask

  vec_t tbl [21];

  initial begin
    int line_addr [8];
    int reads, fs_n, fs_first, fs_second, hs_n, vs_n, blank_n, ridx, first_rd, first_bl;
    bit found;
    line_addr = '{0, 0, 1, 1, 2, 2, 3, 3};
    for (int x = 0; x < 8; x++) begin
      tbl[x]     = '{x, 0, line_addr[x]};
      tbl[8 + x] = '{x, 1, line_addr[x]};
    end
    tbl[16] = '{0, 2, 4};
    tbl[17] = '{1, 2, 4};
    tbl[18] = '{2, 2, 5};
    tbl[19] = '{7, 3, 7};
    tbl[20] = '{0, 0, 0};
    for (int i = 0; i < 3; i++) hist[i] = '0;

    rst = 1'b1;
    repeat (3) step();
    check("reset_scaled", 64'({s_read, s_addr, s_fs, s_blank, s_hs, s_vs}), 64'({1'b0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b1}));
    rst = 1'b0;

    reads = 0; fs_n = 0; fs_first = -1; fs_second = -1; hs_n = 0; vs_n = 0;
    blank_n = 0; ridx = 0; first_rd = -1; first_bl = -1;
    for (int i = 0; i < 2 * HT * VT + 3; i++) begin
      step();
      if (i < 2 * HT * VT) begin
        if (o_read) reads++;
        if (o_read && first_rd < 0) first_rd = i;
        if (o_fs) begin
          fs_n++;
          if (fs_first < 0) fs_first = i;
          else fs_second = i;
        end
      end
      if (i >= 3) begin
        if (!o_hs) hs_n++;
        if (!o_vs) vs_n++;
        if (o_blank) begin
          blank_n++;
          check("raster_red", 64'(o_r), 64'(ridx % 32));
          ridx++;
        end
      end
      if (o_blank && first_bl < 0) first_bl = i;
    end
    check("reads_2frames", 64'(reads), 64'd64);
    check("frame_starts", 64'(fs_n), 64'd2);
    check("frame_period", 64'(fs_second - fs_first), 64'd120);
    check("hsync_clocks", 64'(hs_n), 64'd48);
    check("vsync_clocks", 64'(vs_n), 64'd60);
    check("blank_clocks", 64'(blank_n), 64'd64);
    check("blank_latency", 64'(first_bl - first_rd), 64'd3);

    for (int t = 0; t < 21; t++) begin
      found = 1'b0;
      for (int g = 0; g < 300 && !found; g++) begin
        step();
        if (s_read && s_x == 11'(tbl[t].x) && s_y == 11'(tbl[t].y)) found = 1'b1;
      end
      if (found) check($sformatf("scale_addr_%0d_%0d", tbl[t].x, tbl[t].y), 64'(s_addr), 64'(tbl[t].addr));
      else fail_bound("scale_wait");
    end

    found = 1'b0;
    for (int g = 0; g < 300 && !found; g++) begin
      if (mh == 5 && mv == 2) found = 1'b1;
      else step();
    end
    if (!found) fail_bound("reach_h5_v2");
    rst = 1'b1;
    step();
    check("midframe_reset", 64'({o_read, o_addr, o_x, o_y, o_fs, o_r, o_blank, o_hs, o_vs, s_addr}),
          64'({1'b0, 20'd0, 11'd0, 11'd0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 20'd0}));
    rst = 1'b0;
    step();
    check("first_fetch_after_reset", 64'({o_read, o_addr, o_fs, o_x, o_y}),
          64'({1'b1, 20'd0, 1'b1, 11'd0, 11'd0}));
    repeat (20) step();

`ifdef VGA_CURSOR_EN
    cur_en = 1'b1;
    found = 1'b0;
    for (int g = 0; g < 300 && !found; g++) begin
      step();
      if (o_fs) found = 1'b1;
    end
    if (!found) fail_bound("cursor_frame");
    repeat (HT * VT + 3) step();
    cur_en = 1'b0;
    repeat (5) step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
